// File: rtl/router_tx_pkg.sv
// Shared types and header packing for the router packet transmitter.
package router_tx_pkg;

  localparam int unsigned HDR_ADDR_W = 2;
  localparam int unsigned HDR_LEN_W  = 6;

  localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StParity,
    StErrChk,
    StDone
  } tx_state_e;

  function automatic logic [7:0] pack_header(input logic [HDR_LEN_W-1:0]  len,
                                             input logic [HDR_ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte store: sequential writes from index 0, asynchronous indexed read.
module router_tx_buf #(
  parameter int unsigned Depth = 63,
  parameter int unsigned CntW  = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [7:0]      wdata_i,
  input  logic [CntW-1:0] raddr_i,
  output logic [7:0]      rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  logic [7:0]      mem_q [Depth];
  logic [CntW-1:0] count_q;

  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[raddr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (we_i && !full_o) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Storage is left unreset; stale contents are unreachable once the count is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i && !full_o) begin
      mem_q[count_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Transmit end of the router input protocol: header, buffered payload, parity, err check.
module router_pkt_tx
  import router_tx_pkg::*;
#(
  parameter int unsigned MAX_PLD  = 63,
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [1:0] dest_addr,
  input  logic       start,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_ready,
  output logic       buf_full,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [7:0]           WaitLast = 8'(ERR_WAIT - 1);
  localparam logic [HDR_LEN_W-1:0] LenOne   = HDR_LEN_W'(1);

  tx_state_e            state_q;
  logic [HDR_LEN_W-1:0] len_q, idx_q, count, len_next, rd_idx;
  logic [7:0]           data_q, parity_q, rd_data, wait_q;
  logic                 pv_q, done_q, err_q, ready_q;
  logic                 wr_fire, start_ok, buf_clr;

  assign wr_fire  = (state_q == StIdle) && wr_en && !buf_full;
  // A write in the start cycle lands first and is counted in the length.
  assign len_next = count + HDR_LEN_W'(wr_fire);
  assign start_ok = (state_q == StIdle) && start && (len_next != '0) &&
                    (dest_addr != ADDR_INVALID);
  assign buf_clr  = (state_q == StDone);
  assign rd_idx   = (state_q == StHeader) ? '0 : idx_q + LenOne;

  router_tx_buf #(
    .Depth(MAX_PLD),
    .CntW (HDR_LEN_W)
  ) u_buf (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (buf_clr),
    .we_i   (wr_fire),
    .wdata_i(wr_data),
    .raddr_i(rd_idx),
    .rdata_o(rd_data),
    .count_o(count),
    .full_o (buf_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      len_q    <= '0;
      idx_q    <= '0;
      parity_q <= '0;
      wait_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q  <= StHeader;
            len_q    <= len_next;
            idx_q    <= '0;
            parity_q <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= pack_header(len_next, dest_addr);
            pv_q     <= 1'b1;
          end
        end
        StHeader: begin
          if (!busy) begin
            state_q  <= StPayload;
            parity_q <= parity_q ^ data_q;
            data_q   <= rd_data;
          end
        end
        StPayload: begin
          if (!busy) begin
            parity_q <= parity_q ^ data_q;
            if (idx_q == len_q - LenOne) begin
              state_q <= StParity;
              data_q  <= parity_q ^ data_q;
              pv_q    <= 1'b0;
            end else begin
              idx_q  <= idx_q + LenOne;
              data_q <= rd_data;
            end
          end
        end
        StParity: begin
          if (!busy) begin
            state_q <= StErrChk;
            wait_q  <= '0;
          end
        end
        StErrChk: begin
          if (err) begin
            err_q <= 1'b1;
          end
          wait_q <= wait_q + 8'd1;
          if (wait_q == WaitLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          idx_q   <= '0;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out  = data_q;
  assign pkt_valid = pv_q;
  assign tx_ready  = ready_q;
  assign tx_done   = done_q;
  assign tx_err    = err_q;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the router's input port: pkt_valid, an 8-bit data byte, and busy back-pressure.
- Payload bytes are buffered locally. On start the block emits a header, then the payload, then a parity byte.
- After the parity byte it watches the router's err line and reports the result.
- Sits between a host/test-traffic generator and the router top; it is the transmit end of the router's input protocol.

Parameters:
- MAX_PLD, 63, payload buffer depth in bytes; must not exceed 63, the limit of the 6-bit header length field.
- ERR_WAIT, 3, number of cycles err is sampled after the parity byte is accepted.

Ports:
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write wr_data into the payload buffer; honoured only while tx_ready=1.
- wr_data  in  8  payload byte.
- dest_addr  in  2  destination port, 0..2; sampled on start.
- start  in  1  single-cycle request to send the buffered packet.
- busy  in  1  router back-pressure; a presented byte is accepted at an edge where busy=0.
- err  in  1  router parity-error flag.
- data_out  out  8  byte presented to the router.
- pkt_valid  out  1  high for header and payload bytes, low for the parity byte.
- tx_ready  out  1  idle; buffer writes and start are accepted.
- buf_full  out  1  buffer count equals MAX_PLD.
- tx_done  out  1  one-cycle pulse at the end of the packet.
- tx_err  out  1  err was seen in the last packet; sticky until the next accepted start.

Behaviour:
- Reset: the next state is IDLE and the buffer count is 0.
  - data_out=0, pkt_valid=0, tx_done=0, tx_err=0, tx_ready=1, buf_full=0.
  - Reset mid-packet aborts the packet: pkt_valid=0 in the next cycle and the buffer contents are discarded.
- State machine: IDLE, HEADER, PAYLOAD, PARITY, ERR_CHK, DONE.
- IDLE:
  - wr_en with count<MAX_PLD writes at index count, then count increments.
  - wr_en with count==MAX_PLD is dropped; buf_full stays 1.
  - start with count>=1 and dest_addr!=3: latch addr and length, go to HEADER, clear tx_err. Outputs appear the next cycle (1-cycle latency).
  - start with count==0 or dest_addr==3 is ignored: state stays IDLE and no output changes.
  - Simultaneous wr_en and start: the write completes first and the length includes it.
- HEADER: data_out={len[5:0],addr[1:0]}, pkt_valid=1. Advance to PAYLOAD at an edge with busy=0.
- PAYLOAD:
  - data_out=buf[idx], pkt_valid=1.
  - At each edge with busy=0, idx increments.
  - After idx==len-1 is accepted, go to PARITY.
  - While busy=1, data_out and pkt_valid hold stable; no bubbles are inserted.
- PARITY:
  - data_out = XOR of the header and all payload bytes; pkt_valid=0.
  - Accepted at an edge with busy=0, then go to ERR_CHK.
- ERR_CHK: lasts exactly ERR_WAIT cycles with pkt_valid=0. err=1 in any of these cycles sets tx_err.
- DONE: tx_done=1 for one cycle, count and idx are cleared, then return to IDLE.
- Outside IDLE: tx_ready=0; wr_en and start are ignored.
- Parity accumulates incrementally as bytes are accepted, never recomputed; 8-bit XOR, no carry.
- data_out holds its last value while in IDLE, except that reset clears it.

Decomposition:
- Package router_tx_pkg holds:
  - the state enum;
  - HDR_ADDR_W=2, HDR_LEN_W=6;
  - ADDR_INVALID=2'b11;
  - the header-packing function.
- One sub-module, router_tx_buf: MAX_PLD x 8 storage with write pointer/count, asynchronous read by index, clear input, full flag.

Test Plan:
- Write 0x11,0x22,0x33; start with addr=1; busy=0 → data_out sequence 0x0D(pv=1), 0x11, 0x22, 0x33(pv=1), 0x0D(pv=0); tx_done exactly ERR_WAIT+1 cycles after parity is accepted; tx_err=0.
- Same packet with busy=1 for 2 cycles after the header and 3 cycles mid-payload → each byte held stable while busy; byte order and parity unchanged; no byte duplicated or skipped.
- Write 63 bytes of 0xFF, then a 64th write; start with addr=2 → buf_full=1, 64th byte dropped; header 0xFE; 63 payload bytes; parity 0xFE^0xFF(odd count)=0x01.
- start with an empty buffer, and start with dest_addr=3 → no pkt_valid activity; tx_ready stays 1.
- err pulsed 2 cycles after parity is accepted → tx_err=1 after tx_done; cleared by the next accepted start.
- reset asserted during PAYLOAD → pkt_valid=0 next cycle; tx_ready=1; count=0; a subsequent packet sends correctly.
